// File: rtl/tx_uart.sv
// UART transmitter with runtime frame/baud configuration, strobe/busy handshake
// and a forced-break mode followed by a one-baud idle guard.
module tx_uart (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [29:0] i_setup,
  input  logic        i_break,
  input  logic        i_wr,
  input  logic [7:0]  i_data,
  output logic        o_uart,
  output logic        o_busy
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_BREAK  = 3'd5;
  localparam logic [2:0] S_GUARD  = 3'd6;

  // Counter reload for one bit time; CPB below 2 is clamped to 2.
  function automatic logic [23:0] baud_reload(input logic [29:0] setup);
    if (setup[23:0] < 24'd2)
      return 24'd1;
    else
      return setup[23:0] - 24'd1;
  endfunction

  logic [2:0]  r_state;
  logic [23:0] r_baud;
  logic [2:0]  r_bitcnt;
  logic        r_stop2;
  logic [7:0]  r_data;
  logic [29:0] r_setup;
  logic        r_uart;
  logic        r_busy;

  logic [2:0]  w_last_idx;
  logic [2:0]  w_next_idx;
  logic [7:0]  w_mask;
  logic        w_xor;
  logic        w_parity;
  logic        w_last_stop;

  assign w_last_idx  = 3'd7 - {1'b0, r_setup[29:28]};
  assign w_next_idx  = r_bitcnt + 3'd1;
  assign w_mask      = 8'hFF >> r_setup[29:28];
  assign w_xor       = ^(r_data & w_mask);
  assign w_parity    = r_setup[25] ? r_setup[24] : (r_setup[24] ? w_xor : ~w_xor);
  assign w_last_stop = !r_setup[27] || r_stop2;

  // Busy is low only in IDLE and in the final clock of the last stop bit,
  // so accepting there chains frames without an idle gap.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state  <= S_IDLE;
      r_baud   <= '0;
      r_bitcnt <= '0;
      r_stop2  <= 1'b0;
      r_data   <= '0;
      r_setup  <= '0;
      r_uart   <= 1'b1;
      r_busy   <= 1'b0;
    end else if (i_break) begin
      r_state <= S_BREAK;
      r_uart  <= 1'b0;
      r_busy  <= 1'b1;
    end else if (i_wr && !r_busy) begin
      r_state <= S_START;
      r_data  <= i_data;
      r_setup <= i_setup;
      r_baud  <= baud_reload(i_setup);
      r_uart  <= 1'b0;
      r_busy  <= 1'b1;
    end else begin
      case (r_state)
        S_START: begin
          if (r_baud == 24'd0) begin
            r_state  <= S_DATA;
            r_bitcnt <= 3'd0;
            r_uart   <= r_data[0];
            r_baud   <= baud_reload(r_setup);
          end else begin
            r_baud <= r_baud - 24'd1;
          end
        end
        S_DATA: begin
          if (r_baud == 24'd0) begin
            r_baud <= baud_reload(r_setup);
            if (r_bitcnt == w_last_idx) begin
              if (r_setup[26]) begin
                r_state <= S_PARITY;
                r_uart  <= w_parity;
              end else begin
                r_state <= S_STOP;
                r_stop2 <= 1'b0;
                r_uart  <= 1'b1;
              end
            end else begin
              r_bitcnt <= w_next_idx;
              r_uart   <= r_data[w_next_idx];
            end
          end else begin
            r_baud <= r_baud - 24'd1;
          end
        end
        S_PARITY: begin
          if (r_baud == 24'd0) begin
            r_state <= S_STOP;
            r_stop2 <= 1'b0;
            r_uart  <= 1'b1;
            r_baud  <= baud_reload(r_setup);
          end else begin
            r_baud <= r_baud - 24'd1;
          end
        end
        S_STOP: begin
          if (r_baud == 24'd0) begin
            if (w_last_stop) begin
              r_state <= S_IDLE;
            end else begin
              r_stop2 <= 1'b1;
              r_baud  <= baud_reload(r_setup);
            end
          end else begin
            r_baud <= r_baud - 24'd1;
            if (w_last_stop && r_baud == 24'd1)
              r_busy <= 1'b0;
          end
        end
        S_BREAK: begin
          r_state <= S_GUARD;
          r_uart  <= 1'b1;
          r_baud  <= baud_reload(i_setup);
        end
        S_GUARD: begin
          if (r_baud == 24'd0) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_baud <= r_baud - 24'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_uart  <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_uart = r_uart;
  assign o_busy = r_busy;

endmodule

// File: tb/tb_tx_uart.sv
// Scoreboard bench for tx_uart: stimulus pushes expected frames, a monitor
// checks the line and busy cycle by cycle against them.
module tb_tx_uart;

  logic        clk = 1'b0;
  logic        i_reset_n;
  logic [29:0] i_setup;
  logic        i_break;
  logic        i_wr;
  logic [7:0]  i_data;
  logic        o_uart;
  logic        o_busy;

  tx_uart dut (
    .i_clk     (clk),
    .i_reset_n (i_reset_n),
    .i_setup   (i_setup),
    .i_break   (i_break),
    .i_wr      (i_wr),
    .i_data    (i_data),
    .o_uart    (o_uart),
    .o_busy    (o_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] bits;
    int          nb;
    int          cpb;
    logic [7:0]  d;
  } frame_t;

  frame_t exp_q[$];
  int     starts[$];
  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  bit     mon_en = 1'b1;
  bit     mon_active = 1'b0;
  logic   prev_busy = 1'b0;
  frame_t mf;
  int     mT;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: the frame as a list of line levels, one per bit time.
  function automatic frame_t model(input logic [7:0] d, input logic [29:0] s);
    frame_t f;
    int n;
    int ones;
    logic p;
    n = 8 - int'(s[29:28]);
    f.cpb = (s[23:0] < 24'd2) ? 2 : int'(s[23:0]);
    f.d = d;
    f.bits = '0;
    f.nb = 1;
    ones = 0;
    for (int i = 0; i < n; i++) begin
      f.bits[f.nb] = d[i];
      if (d[i]) ones++;
      f.nb++;
    end
    if (s[26]) begin
      if (s[25]) p = s[24];
      else if (s[24]) p = (ones % 2 == 1);
      else p = (ones % 2 == 0);
      f.bits[f.nb] = p;
      f.nb++;
    end
    f.bits[f.nb] = 1'b1;
    f.nb++;
    if (s[27]) begin
      f.bits[f.nb] = 1'b1;
      f.nb++;
    end
    return f;
  endfunction

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && o_busy === 1'b1 && prev_busy === 1'b0) begin
        mon_active = 1'b1;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame at cycle %0d: got frame expected none", cyc);
        end else begin
          mf = exp_q.pop_front();
          starts.push_back(cyc);
          mT = mf.nb * mf.cpb;
          for (int c = 0; c < mT; c++) begin
            if (c > 0) @(negedge clk);
            chk($sformatf("uart_d%02h_c%0d", mf.d, c), o_uart, mf.bits[c / mf.cpb]);
            chk($sformatf("busy_d%02h_c%0d", mf.d, c), o_busy, (c != mT - 1));
          end
        end
        mon_active = 1'b0;
      end
      prev_busy = o_busy;
    end
  end

  task automatic send(input logic [7:0] d, input logic [29:0] s, input bit push);
    i_wr = 1'b1;
    i_data = d;
    i_setup = s;
    @(posedge clk);
    #1;
    i_wr = 1'b0;
    i_setup = 30'($urandom);
    if (push) exp_q.push_back(model(d, s));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || mon_active) && n < 5000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 5000) begin
      checks++;
      errors++;
      $display("FAIL wait_idle_timeout: got %0d pending expected 0", exp_q.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  localparam logic [29:0] SET_8N1_4 = {2'b00, 1'b0, 3'b000, 24'd4};
  localparam logic [29:0] SET_8N1_8 = {2'b00, 1'b0, 3'b000, 24'd8};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  rd;
    logic [29:0] rs;
    frame_t      rf;
    int          n;
    string       msg;

    i_reset_n = 1'b0;
    i_setup = SET_8N1_4;
    i_break = 1'b0;
    i_wr = 1'b0;
    i_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_uart", o_uart, 1'b1);
    chk("reset_busy", o_busy, 1'b0);
    @(negedge clk);
    i_reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed frames: 8N1 0x55, then 7E2 / stick / odd variants of 0x41.
    send(8'h55, SET_8N1_4, 1'b1);
    wait_idle();
    send(8'h41, {2'b01, 1'b1, 1'b1, 1'b0, 1'b1, 24'd3}, 1'b1);
    wait_idle();
    send(8'h41, {2'b01, 1'b1, 1'b1, 1'b1, 1'b1, 24'd3}, 1'b1);
    wait_idle();
    send(8'h41, {2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 24'd3}, 1'b1);
    wait_idle();

    // A write while busy must be dropped.
    send(8'h3C, SET_8N1_4, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    i_wr = 1'b1;
    i_data = 8'hAA;
    @(posedge clk);
    #1;
    i_wr = 1'b0;
    wait_idle();

    // Random frames, sometimes launched on the exact edge busy drops.
    for (int k = 0; k < 20; k++) begin
      rd = 8'($urandom);
      rs = 30'($urandom);
      rs[23:0] = 24'($urandom_range(0, 6));
      rf = model(rd, rs);
      send(rd, rs, 1'b1);
      repeat (rf.nb * rf.cpb - 1 + int'($urandom_range(0, 3))) @(posedge clk);
      #1;
    end
    wait_idle();

    // Back-to-back stream paced by busy.
    msg = "Hello, World! \r\n";
    starts.delete();
    for (int i = 0; i < 16; i++) begin
      n = 0;
      @(negedge clk);
      while (o_busy && n < 1000) begin
        @(negedge clk);
        n++;
      end
      if (n >= 1000) chk_int("b2b_busy_timeout", n, 0);
      i_wr = 1'b1;
      i_data = msg[i];
      i_setup = SET_8N1_8;
      @(posedge clk);
      #1;
      i_wr = 1'b0;
      exp_q.push_back(model(msg[i], SET_8N1_8));
    end
    wait_idle();
    chk_int("b2b_frames", starts.size(), 16);
    for (int i = 0; i + 1 < starts.size(); i++)
      chk_int($sformatf("b2b_gap_%0d", i), starts[i + 1] - starts[i], 80);

    // Break mid-frame, then one-CPB guard.
    mon_en = 1'b0;
    i_setup = SET_8N1_4;
    i_data = 8'hFF;
    i_wr = 1'b1;
    @(posedge clk);
    #1;
    i_wr = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    i_break = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 49; i++) begin
      @(negedge clk);
      chk("break_uart", o_uart, 1'b0);
      chk("break_busy", o_busy, 1'b1);
    end
    @(posedge clk);
    #1;
    i_break = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("guard_uart", o_uart, 1'b1);
      chk("guard_busy", o_busy, 1'b1);
    end
    @(negedge clk);
    chk("guard_end_uart", o_uart, 1'b1);
    chk("guard_end_busy", o_busy, 1'b0);
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // Asynchronous reset in the middle of a low data bit.
    mon_en = 1'b0;
    i_setup = SET_8N1_4;
    i_data = 8'hF0;
    i_wr = 1'b1;
    @(posedge clk);
    #1;
    i_wr = 1'b0;
    repeat (14) @(posedge clk);
    #3;
    chk("pre_reset_uart", o_uart, 1'b0);
    i_reset_n = 1'b0;
    #1;
    chk("async_reset_uart", o_uart, 1'b1);
    chk("async_reset_busy", o_busy, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    i_reset_n = 1'b1;
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    send(8'hC3, SET_8N1_4, 1'b1);
    wait_idle();

    chk_int("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tx_uart.md
# tx_uart

Configurable UART transmitter that serializes one character at a time onto a single output line. Frame format and baud rate come from a 30-bit setup word, so one instance serves any standard frame (5–8 data bits, optional parity, 1–2 stop bits). It sits behind a simple strobe/busy handshake and is driven directly by a character source such as a message ROM sequencer or a bus-side FIFO.

## Interface

- No parameters; all configuration is runtime via `i_setup`.
- `i_clk` input 1: system clock; all logic on rising edge.
- `i_reset_n` input 1: reset, asynchronous and active-low.
- `i_setup` input 30: frame and baud configuration.
  - [29:28] data bits: 00=8, 01=7, 10=6, 11=5.
  - [27] stop bits: 0=one, 1=two.
  - [26] parity enable.
  - [25] fixed (stick) parity.
  - [24] parity select.
  - [23:0] clocks per baud (CPB).
- `i_break` input 1: force break (line low) while high.
- `i_wr` input 1: write strobe; character is accepted when `i_wr && !o_busy`.
- `i_data` input 8: character; LSBs are used when fewer than 8 data bits are configured.
- `o_uart` output 1: serial line, idles high.
- `o_busy` output 1: transmitter cannot accept a character.

## Operation

- Reset (`i_reset_n`=0, asynchronous): `o_uart`=1, `o_busy`=0, state IDLE, counters cleared. Reset mid-frame aborts the frame immediately; the line returns high.
- States: IDLE → START → DATA → PARITY (only if enabled) → STOP (1 or 2 bits) → IDLE. A separate BREAK condition is described below.
- Accept: in IDLE with `i_wr`=1 and `i_break`=0, the module latches `i_data` and the whole of `i_setup`. Later changes to `i_setup` affect only the next frame.
- START: line 0 for one baud period.
- DATA: N bits, LSB first.
- PARITY: one baud period.
  - Fixed parity ([25]=1): bit = `i_setup[24]`.
  - Otherwise [24]=1 selects even parity: bit = XOR of the N sent data bits.
  - Otherwise [24]=0 selects odd parity: bit = XNOR of the N sent data bits.
- STOP: line 1 for one or two baud periods.
- Each bit lasts exactly CPB clocks. A CPB value below 2 is treated as 2.
- Frame length T = (1 + N + P + S) × CPB clocks, where P is 0/1 for parity and S is 1/2 stop bits.
- `i_wr` while `o_busy`=1 is ignored; no queueing.
- Break: while `i_break`=1, `o_uart`=0 and `o_busy`=1, regardless of state. An in-progress frame is abandoned.
  - When `i_break` falls, the line goes high and `o_busy` stays 1 for one full CPB period (idle guard), then the module returns to IDLE.
- Simultaneous `i_wr` and `i_break` in IDLE: break wins and the character is dropped.

## Timing

- Write accepted at edge k:
  - `o_busy`=1 from k+1.
  - Start bit on `o_uart` for cycles k+1 … k+CPB.
  - Bit j occupies cycles k+1+j·CPB … k+(j+1)·CPB.
- `o_busy` drops during the final clock of the last stop bit (cycle k+T). A write accepted at that edge produces the next start bit at k+T+1, so back-to-back characters have no idle gap.
- `o_uart` and `o_busy` are registered outputs; there is no combinational path from inputs to outputs.
- Baud counter: 24-bit down-counter reloaded with CPB−1 at each bit boundary.

## Test plan

- 8N1, CPB=4, `i_data`=0x55 → `o_uart` = 0,1,0,1,0,1,0,1,0,1, each value held 4 clocks. `o_busy` high for 40 clocks starting the cycle after the write.
- Back-to-back stream: 8N1, CPB=8, write "Hello, World! \r\n" (16 bytes) whenever `!o_busy` → 16 contiguous 80-clock frames with no idle gap. The decoded bytes match in order.
- 7E2, CPB=3, `i_data`=0x41 → bits 0,1,0,0,0,0,0,1, parity 0, stop 1,1 (11 bits, 33 clocks). With [25]=1 and [24]=1 the parity bit becomes 1. With odd parity selected it becomes 1.
- Write ignored: issue a second `i_wr` (0xAA) mid-frame → only the first character is sent, and `o_busy` timing is unchanged.
- Break: assert `i_break` mid-frame for 50 clocks, CPB=4 → `o_uart`=0 during the break. After release, the line is high with `o_busy`=1 for 4 clocks, then `o_busy`=0.
- Async reset mid-data-bit → `o_uart`=1 and `o_busy`=0 immediately, without waiting for a clock edge. A new write after release transmits cleanly.
